decode_hazard_ctrl: RTL and testbench



---
 rtl/riscv_pkg.sv | 23 ++
 rtl/decode_hazard_ctrl_src_use_dec.sv | 29 ++
 rtl/decode_hazard_ctrl.sv | 98 +++++++++
 tb/tb_decode_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: opcodes, the canonical NOP and
// the decode-stage control state.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    RUN,
    STALL
  } ctrl_state_t;

endpackage

// File: rtl/decode_hazard_ctrl_src_use_dec.sv
// Opcode to source-register usage; shared with the ID decoder.
// LUI, AUIPC and JAL read no register.
module src_use_dec
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       rs1_used,
  output logic       rs2_used
);

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    unique case (opcode)
      OP_REG, OP_STORE, OP_BRANCH: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        rs1_used = 1'b1;
      end
      default: begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// IF/ID register owner and decode-stage sequencer:
// advance, load-use stall, memory freeze or redirect flush.
module decode_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              CNT_W    = 16,
  parameter logic [XLEN-1:0] NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid_i,
  input  logic [XLEN-1:0]  if_inst_i,
  input  logic [XLEN-1:0]  if_pc_i,
  input  logic             ex_valid_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_redirect_i,
  input  logic             mem_busy_i,
  output logic [XLEN-1:0]  id_inst_o,
  output logic [XLEN-1:0]  id_pc_o,
  output logic             id_valid_o,
  output logic             pc_write_o,
  output logic             idex_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  ctrl_state_t state;
  logic        rs1_used;
  logic        rs2_used;
  logic        rs1_hit;
  logic        rs2_hit;
  logic        lu_haz;

  src_use_dec u_src_use_dec (
    .opcode   (id_inst_o[6:0]),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  assign rs1_hit = rs1_used &&
                   (id_inst_o[19:15] == ex_rd_i);
  assign rs2_hit = rs2_used &&
                   (id_inst_o[24:20] == ex_rd_i);

  // EX holds our own bubble while in STALL, so no recheck there
  assign lu_haz = id_valid_o && ex_valid_i &&
                  ex_mem_read_i &&
                  (ex_rd_i != 5'd0) &&
                  (rs1_hit || rs2_hit) &&
                  (state == RUN);

  always_comb begin
    pc_write_o    = 1'b1;
    idex_bubble_o = 1'b0;
    if (mem_busy_i) begin
      pc_write_o    = 1'b0;
      idex_bubble_o = 1'b0;
    end else if (ex_redirect_i) begin
      pc_write_o    = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (lu_haz) begin
      pc_write_o    = 1'b0;
      idex_bubble_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_inst_o   <= NOP_INST;
      id_pc_o     <= '0;
      id_valid_o  <= 1'b0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
      state       <= RUN;
    end else if (mem_busy_i) begin
      state <= state;
    end else if (ex_redirect_i) begin
      id_inst_o  <= NOP_INST;
      id_pc_o    <= if_pc_i;
      id_valid_o <= 1'b0;
      if (flush_cnt_o != '1)
        flush_cnt_o <= flush_cnt_o + 1'b1;
      state <= RUN;
    end else if (lu_haz) begin
      if (stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + 1'b1;
      state <= STALL;
    end else begin
      id_inst_o  <= if_valid_i ? if_inst_i : NOP_INST;
      id_pc_o    <= if_pc_i;
      id_valid_o <= if_valid_i;
      state      <= RUN;
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Scoreboarded bench for decode_hazard_ctrl; a 4-bit-counter twin
// shares the stimulus so saturation is reachable quickly.
module tb_decode_hazard_ctrl;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] I_ADD = 32'h0072_8333;
  localparam logic [31:0] I_LW  = 32'h0002_a383;
  localparam logic [31:0] I_SW  = 32'h0053_2023;
  localparam logic [31:0] I_BEQ = 32'h0002_8063;
  localparam logic [31:0] I_JR  = 32'h0002_8067;
  localparam logic [31:0] I_AI  = 32'h0012_8093;
  localparam logic [31:0] I_LUI = 32'h0002_82b7;
  localparam logic [31:0] I_JAL = 32'h0080_00ef;
  localparam logic [31:0] I_LI5 = 32'h0050_0093;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid_i;
  logic [31:0] if_inst_i;
  logic [31:0] if_pc_i;
  logic        ex_valid_i;
  logic        ex_mem_read_i;
  logic [4:0]  ex_rd_i;
  logic        ex_redirect_i;
  logic        mem_busy_i;
  logic [31:0] id_inst_o;
  logic [31:0] id_pc_o;
  logic        id_valid_o;
  logic        pc_write_o;
  logic        idex_bubble_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;
  logic [31:0] s_inst;
  logic [31:0] s_pc;
  logic        s_valid;
  logic        s_pcw;
  logic        s_bub;
  logic [3:0]  s_stall;
  logic [3:0]  s_flush;

  decode_hazard_ctrl #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .if_valid_i(if_valid_i), .if_inst_i(if_inst_i),
    .if_pc_i(if_pc_i), .ex_valid_i(ex_valid_i),
    .ex_mem_read_i(ex_mem_read_i), .ex_rd_i(ex_rd_i),
    .ex_redirect_i(ex_redirect_i), .mem_busy_i(mem_busy_i),
    .id_inst_o(id_inst_o), .id_pc_o(id_pc_o),
    .id_valid_o(id_valid_o), .pc_write_o(pc_write_o),
    .idex_bubble_o(idex_bubble_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  decode_hazard_ctrl #(.XLEN(32), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset),
    .if_valid_i(if_valid_i), .if_inst_i(if_inst_i),
    .if_pc_i(if_pc_i), .ex_valid_i(ex_valid_i),
    .ex_mem_read_i(ex_mem_read_i), .ex_rd_i(ex_rd_i),
    .ex_redirect_i(ex_redirect_i), .mem_busy_i(mem_busy_i),
    .id_inst_o(s_inst), .id_pc_o(s_pc),
    .id_valid_o(s_valid), .pc_write_o(s_pcw),
    .idex_bubble_o(s_bub),
    .stall_cnt_o(s_stall), .flush_cnt_o(s_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pcw;
    logic        bub;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic        stl;
    logic [15:0] st16;
    logic [15:0] fl16;
    logic [3:0]  st4;
    logic [3:0]  fl4;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_bad = 0;

  logic        m_known = 1'b0;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_stl;
  logic [15:0] m_st16;
  logic [15:0] m_fl16;
  logic [3:0]  m_st4;
  logic [3:0]  m_fl4;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic use1(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0010011 ||
           op == 7'b0000011 || op == 7'b0100011 ||
           op == 7'b1100011 || op == 7'b1100111;
  endfunction

  function automatic logic use2(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0100011 ||
           op == 7'b1100011;
  endfunction

  task automatic cyc(input logic r, iv,
                     input logic [31:0] ii, ip,
                     input logic ev, em,
                     input logic [4:0] rd,
                     input logic rr, mb);
    exp_t e;
    logic haz;
    reset = r; if_valid_i = iv; if_inst_i = ii;
    if_pc_i = ip; ex_valid_i = ev; ex_mem_read_i = em;
    ex_rd_i = rd; ex_redirect_i = rr; mem_busy_i = mb;
    #1;
    haz = m_valid && ev && em && rd != 5'd0 && !m_stl &&
          ((use1(m_inst[6:0]) && m_inst[19:15] == rd) ||
           (use2(m_inst[6:0]) && m_inst[24:20] == rd));
    e = '{pcw: 1'b1, bub: 1'b0, inst: m_inst, pc: m_pc,
          valid: m_valid, stl: m_stl, st16: m_st16,
          fl16: m_fl16, st4: m_st4, fl4: m_fl4};
    if (mb) begin
      e.pcw = 1'b0;
    end else if (rr) begin
      e.bub = 1'b1;
      e.inst = NOP; e.pc = ip; e.valid = 1'b0;
      e.stl = 1'b0;
      if (m_fl16 != 16'hFFFF) e.fl16 = m_fl16 + 1'b1;
      if (m_fl4 != 4'hF) e.fl4 = m_fl4 + 1'b1;
    end else if (haz) begin
      e.pcw = 1'b0; e.bub = 1'b1; e.stl = 1'b1;
      if (m_st16 != 16'hFFFF) e.st16 = m_st16 + 1'b1;
      if (m_st4 != 4'hF) e.st4 = m_st4 + 1'b1;
    end else begin
      e.inst = iv ? ii : NOP; e.pc = ip;
      e.valid = iv; e.stl = 1'b0;
    end
    if (r) begin
      e.inst = NOP; e.pc = '0; e.valid = 1'b0;
      e.stl = 1'b0; e.st16 = '0; e.fl16 = '0;
      e.st4 = '0; e.fl4 = '0;
    end
    sb.push_back(e);
    if (m_known) begin
      chk("pc_write", {31'd0, pc_write_o}, {31'd0, sb[0].pcw});
      chk("bubble", {31'd0, idex_bubble_o}, {31'd0, sb[0].bub});
      chk("s_bubble", {31'd0, s_bub}, {31'd0, sb[0].bub});
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("id_inst", id_inst_o, e.inst);
    chk("id_pc", id_pc_o, e.pc);
    chk("id_valid", {31'd0, id_valid_o}, {31'd0, e.valid});
    chk("stall_cnt", {16'd0, stall_cnt_o}, {16'd0, e.st16});
    chk("flush_cnt", {16'd0, flush_cnt_o}, {16'd0, e.fl16});
    chk("s_stall", {28'd0, s_stall}, {28'd0, e.st4});
    chk("s_flush", {28'd0, s_flush}, {28'd0, e.fl4});
    m_inst = e.inst; m_pc = e.pc; m_valid = e.valid;
    m_stl = e.stl; m_st16 = e.st16; m_fl16 = e.fl16;
    m_st4 = e.st4; m_fl4 = e.fl4;
    m_known = 1'b1;
    @(negedge clk);
  endtask

  logic [31:0] itab [8];
  logic [4:0]  rtab [4];

  initial begin
    itab = '{I_ADD, I_LW, I_SW, I_BEQ, I_JR, I_AI, I_LUI, I_JAL};
    rtab = '{5'd0, 5'd5, 5'd6, 5'd7};
    reset = 1'b1; if_valid_i = 1'b1; if_inst_i = I_LI5;
    if_pc_i = '0; ex_valid_i = 1'b0; ex_mem_read_i = 1'b0;
    ex_rd_i = '0; ex_redirect_i = 1'b0; mem_busy_i = 1'b0;
    @(negedge clk);

    cyc(1, 1, I_LI5, 32'h0, 0, 0, 0, 0, 0);
    cyc(1, 1, I_LI5, 32'h0, 0, 0, 0, 0, 0);
    chk("rst_valid", {31'd0, id_valid_o}, 32'd0);
    chk("rst_inst", id_inst_o, NOP);
    chk("rst_stall", {16'd0, stall_cnt_o}, 32'd0);
    cyc(0, 1, I_LI5, 32'h0, 0, 0, 0, 0, 0);
    chk("first_inst", id_inst_o, I_LI5);

    cyc(0, 1, I_ADD, 32'h100, 0, 0, 0, 0, 0);
    cyc(0, 1, I_AI, 32'h104, 1, 1, 5'd5, 0, 0);
    chk("lu_stall_cnt", {16'd0, stall_cnt_o}, 32'd1);
    chk("lu_hold", id_inst_o, I_ADD);
    cyc(0, 1, I_AI, 32'h104, 1, 1, 5'd5, 0, 0);
    chk("lu_adv", id_inst_o, I_AI);
    chk("lu_once", {16'd0, stall_cnt_o}, 32'd1);

    cyc(0, 1, I_LI5, 32'h108, 0, 0, 0, 0, 0);
    cyc(0, 1, I_LUI, 32'h10c, 1, 1, 5'd0, 0, 0);
    cyc(0, 1, I_JAL, 32'h110, 1, 1, 5'd5, 0, 0);
    chk("no_false", {16'd0, stall_cnt_o}, 32'd1);

    cyc(0, 1, I_ADD, 32'h200, 0, 0, 0, 0, 0);
    cyc(0, 1, I_AI, 32'h300, 1, 1, 5'd7, 1, 0);
    chk("fl_valid", {31'd0, id_valid_o}, 32'd0);
    chk("fl_inst", id_inst_o, NOP);
    chk("fl_cnt", {16'd0, flush_cnt_o}, 32'd1);
    chk("fl_stall", {16'd0, stall_cnt_o}, 32'd1);

    cyc(0, 1, I_SW, 32'h304, 0, 0, 0, 0, 0);
    cyc(0, 1, I_AI, 32'h308, 1, 1, 5'd6, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc(0, 1, I_AI, 32'h308, 1, 1, 5'd6, 0, 1);
    chk("frz_hold", id_inst_o, I_SW);
    cyc(0, 1, I_AI, 32'h308, 1, 1, 5'd6, 0, 0);
    chk("frz_adv", id_inst_o, I_AI);
    chk("frz_cnt", {16'd0, stall_cnt_o}, 32'd2);

    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(63) == 0),
          ($urandom_range(7) != 0),
          itab[$urandom_range(7)],
          32'h1000 + 4 * i,
          ($urandom_range(3) != 0),
          ($urandom_range(1) == 1),
          rtab[$urandom_range(3)],
          ($urandom_range(9) == 0),
          ($urandom_range(7) == 0));

    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, I_ADD, 32'h2000, 0, 0, 0, 0, 0);
      cyc(0, 1, I_AI, 32'h2004, 1, 1, 5'd5, 0, 0);
      cyc(0, 1, I_JAL, 32'h2008, 0, 0, 0, 1, 0);
    end
    chk("sat_stall", {28'd0, s_stall}, 32'hF);
    chk("sat_flush", {28'd0, s_flush}, 32'hF);
    cyc(0, 1, I_ADD, 32'h2000, 0, 0, 0, 0, 0);
    cyc(0, 1, I_AI, 32'h2004, 1, 1, 5'd5, 0, 0);
    chk("sat_hold", {28'd0, s_stall}, 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
